// File: rtl/seq_add64.sv
// Sequential 64-bit adder: one 16-bit ripple slice reused over four RUN cycles,
// with a valid/ready handshake on both the operand and the result side.
module seq_add64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] sum,
  output logic        cout,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [63:0] a_q, a_d;
  logic [63:0] b_q, b_d;
  logic [63:0] sum_q, sum_d;
  logic        carry_q, carry_d;
  logic        cout_q, cout_d;
  logic        ovf_q, ovf_d;
  logic [1:0]  k_q, k_d;

  logic [15:0] slice_a, slice_b, slice_s;
  logic [16:0] rc;

  assign slice_a = a_q[{k_q, 4'b0000} +: 16];
  assign slice_b = b_q[{k_q, 4'b0000} +: 16];
  assign rc[0]   = carry_q;

  // The single shared slice: a plain chain of full adders fed by the carry register.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_fa
      assign slice_s[gi] = slice_a[gi] ^ slice_b[gi] ^ rc[gi];
      assign rc[gi+1]    = (slice_a[gi] & slice_b[gi]) | (rc[gi] & (slice_a[gi] ^ slice_b[gi]));
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)     state_d = RUN;
      RUN:     if (k_q == 2'd3)  state_d = DONE;
      DONE:    if (out_ready)    state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          k_d     = 2'd0;
        end
      end
      RUN: begin
        sum_d[{k_q, 4'b0000} +: 16] = slice_s;
        carry_d = rc[16];
        k_d     = k_q + 2'd1;
        if (k_q == 2'd3) begin
          cout_d = rc[16];
          ovf_d  = (a_q[63] == b_q[63]) && (slice_s[15] != a_q[63]);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      k_q     <= 2'd0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      k_q     <= k_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/seq_add64.md
SEQ_ADD64 -- requirements
Module: seq_add64

Interface
REQ-001 SHALL declare no parameters; slice width fixed at 16 bits, operand width 64 bits, 4 slices.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operands a, b, cin valid this cycle.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  64  addend A, unsigned or two's complement.
REQ-007 SHALL have port b  input  64  addend B.
REQ-008 SHALL have port cin  input  1  carry-in to bit 0.
REQ-009 SHALL have port out_valid  output  1  sum, cout, ovf valid.
REQ-010 SHALL have port out_ready  input  1  downstream consumes result.
REQ-011 SHALL have port sum  output  64  a + b + cin modulo 2^64.
REQ-012 SHALL have port cout  output  1  carry out of bit 63.
REQ-013 SHALL have port ovf  output  1  two's-complement overflow: (a[63]==b[63]) && (sum[63]!=a[63]).

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE, with exactly one 16-bit ripple adder slice reused each RUN cycle.
REQ-015 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 SHALL accept on in_valid && in_ready edge: latch a, b; carry register <= cin; slice counter <= 0; IDLE->RUN.
REQ-017 SHALL, each RUN cycle with counter k, compute slice k = a[16k+15:16k] + b[16k+15:16k] + carry, write it to sum[16k+15:16k], update carry with the slice carry-out, increment k.
REQ-018 SHALL process slices strictly in order k=0,1,2,3; carry between slices only through the carry register.
REQ-019 SHALL transition RUN->DONE on the edge processing k=3; cout <= that slice's carry-out; ovf computed from latched a[63], b[63] and new sum[63].
REQ-020 SHALL yield latency of exactly 4 clock edges from the accepting edge to out_valid high; throughput one operation per >=5 cycles.
REQ-021 SHALL hold sum, cout, ovf, out_valid stable in DONE while out_ready=0, for any number of cycles.
REQ-022 SHALL transition DONE->IDLE on out_valid && out_ready; no new operand acceptance on that same edge.
REQ-023 SHALL ignore in_valid, a, b, cin outside IDLE; operand changes during RUN SHALL not affect the result.
REQ-024 SHALL keep sum, cout, ovf at their last DONE values in IDLE until the next RUN overwrites them slice by slice.
REQ-025 SHALL wrap the counter only via the RUN->DONE transition; k never exceeds 3.

Reset
REQ-026 SHALL, on rst_n=0, immediately and regardless of clk force state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, carry=0, counter=0.
REQ-027 SHALL abort any in-progress RUN or pending DONE on reset assertion; partial result discarded, no out_valid pulse.
REQ-028 SHALL accept operands on the first rising edge after rst_n deasserts if in_valid=1.

Verification
REQ-029 Basic: a=0x00AA, b=0x000F, cin=1, out_ready=1 -> out_valid 4 edges after accept, sum=0x00BA, cout=0, ovf=0.
REQ-030 Inter-slice carry: a=0x0000_0000_FFFF_FFFF, b=1, cin=0 -> sum=0x0000_0001_0000_0000, cout=0.
REQ-031 Full ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, ovf=0; a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=0x8000_0000_0000_0000, ovf=1.
REQ-032 Backpressure: out_ready=0 for 3 cycles in DONE; toggle a, b, in_valid meanwhile -> outputs stable, in_ready=0; out_ready=1 -> IDLE next edge.
REQ-033 Reset mid-RUN: assert rst_n=0 after slice 1 -> outputs zero at once, in_ready=1; next operation a=5, b=7, cin=0 -> sum=12.
REQ-034 Random: 1000 random a, b, cin with random out_ready stalls vs reference model; sum, cout, ovf match every transaction.
